// File: rtl/ooo_pkg.sv
// Shared common-data-bus definitions used by the reservation stations, the ROB
// and the CDB arbiter.
package ooo_pkg;
  localparam int ROBID_BITS = 7;
  localparam int VALUE_SIZE = 32;

  // robid sits in the upper bits so the packed struct matches the CDB port layout
  typedef struct packed {
    logic [ROBID_BITS-1:0] robid;
    logic [VALUE_SIZE-1:0] value;
  } cdb_t;
endpackage

// File: rtl/cdb_hold_fifo.sv
// Per-unit hold FIFO: a circular buffer that parks finished results until
// the arbiter grants the unit a CDB slot. State updates on the falling edge.
module cdb_hold_fifo #(
  parameter int WIDTH = 39,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             not_full,
  output logic             not_empty,
  output logic [WIDTH-1:0] head
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign not_full  = (count < CNT_W'(DEPTH));
  assign not_empty = (count != '0);
  assign head      = mem[rd_ptr];
  assign push_ok   = push && not_full;
  assign pop_ok    = pop && not_empty;

  always_ff @(negedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= bump(wr_ptr);
      if (pop_ok)  rd_ptr <= bump(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage carries no reset; count alone decides what is valid.
  always_ff @(negedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that broadcasts at most one buffered execution-unit
// result per cycle on the common data bus, stalled while the ROB is full.
module cdb_arbiter #(
  parameter int NUM_UNITS  = 4,
  parameter int UNIT_BITS  = 2,
  parameter int ROBID_BITS = ooo_pkg::ROBID_BITS,
  parameter int VALUE_SIZE = ooo_pkg::VALUE_SIZE,
  parameter int HOLD_DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_UNITS-1:0]             unit_valid,
  input  logic [NUM_UNITS*ROBID_BITS-1:0]  unit_robid,
  input  logic [NUM_UNITS*VALUE_SIZE-1:0]  unit_value,
  output logic [NUM_UNITS-1:0]             unit_ready,
  input  logic                             robfull,
  output logic [ROBID_BITS+VALUE_SIZE-1:0] CDB,
  output logic                             cdb_valid,
  output logic [UNIT_BITS-1:0]             cdb_unit
);
  localparam int ENTRY_W = ROBID_BITS + VALUE_SIZE;

  // Handshake: a result moves into hold FIFO i on a falling edge where
  // unit_valid[i] && unit_ready[i]; ready depends only on registered count.
  logic [NUM_UNITS-1:0] not_full;
  logic [NUM_UNITS-1:0] not_empty;
  logic [NUM_UNITS-1:0] push;
  logic [NUM_UNITS-1:0] pop;
  logic [ENTRY_W-1:0]   head [NUM_UNITS];

  logic [UNIT_BITS-1:0] rr_ptr;
  logic [UNIT_BITS-1:0] grant_idx;
  logic                 grant_found;
  logic [ENTRY_W-1:0]   grant_data;
  int                   scan_idx;

  assign unit_ready = not_full & {NUM_UNITS{rst}};
  assign push       = unit_valid & unit_ready;

  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_unit
    assign pop[i] = grant_found && (grant_idx == UNIT_BITS'(i));

    cdb_hold_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (HOLD_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[i]),
      .pop       (pop[i]),
      .din       ({unit_robid[i*ROBID_BITS +: ROBID_BITS],
                   unit_value[i*VALUE_SIZE +: VALUE_SIZE]}),
      .not_full  (not_full[i]),
      .not_empty (not_empty[i]),
      .head      (head[i])
    );
  end

  // Rotating-priority scan starting at rr_ptr; first non-empty FIFO wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_data  = '0;
    scan_idx    = 0;
    if (!robfull) begin
      for (int k = 0; k < NUM_UNITS; k++) begin
        scan_idx = int'(rr_ptr) + k;
        if (scan_idx >= NUM_UNITS) scan_idx = scan_idx - NUM_UNITS;
        if (!grant_found && not_empty[scan_idx]) begin
          grant_found = 1'b1;
          grant_idx   = UNIT_BITS'(scan_idx);
          grant_data  = head[scan_idx];
        end
      end
    end
  end

  always_ff @(negedge clk) begin
    if (!rst) begin
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
      CDB       <= '0;
      cdb_unit  <= '0;
    end else if (grant_found) begin
      CDB       <= grant_data;
      cdb_unit  <= grant_idx;
      cdb_valid <= 1'b1;
      rr_ptr    <= (grant_idx == UNIT_BITS'(NUM_UNITS - 1)) ? '0 : grant_idx + 1'b1;
    end else begin
      cdb_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, hand sequences for the
// multi-cycle corners, and random traffic against a queue-based model.
module tb_cdb_arbiter;
  import ooo_pkg::*;

  localparam int NU    = 4;
  localparam int RB    = 7;
  localparam int VS    = 32;
  localparam int DEPTH = 2;

  logic         clk;
  logic         rst;
  logic [3:0]   unit_valid;
  logic [27:0]  unit_robid;
  logic [127:0] unit_value;
  logic [3:0]   unit_ready;
  logic         robfull;
  logic [38:0]  CDB;
  logic         cdb_valid;
  logic [1:0]   cdb_unit;

  cdb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .unit_valid (unit_valid),
    .unit_robid (unit_robid),
    .unit_value (unit_value),
    .unit_ready (unit_ready),
    .robfull    (robfull),
    .CDB        (CDB),
    .cdb_valid  (cdb_valid),
    .cdb_unit   (cdb_unit)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: one queue per unit plus a rotating start index
  cdb_t       mq [NU][$];
  int         m_rr    = 0;
  logic       m_valid = 1'b0;
  logic [1:0] m_unit  = 2'd0;
  cdb_t       m_cdb   = '0;

  typedef struct {
    logic         r;
    logic [3:0]   v;
    logic         rf;
    logic [27:0]  rid;
    logic [127:0] val;
    logic         e_valid;
    logic [1:0]   e_unit;
    logic [38:0]  e_cdb;
    logic [3:0]   e_ready;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [27:0] rid_at(input int u, input logic [6:0] r);
    logic [27:0] x;
    x = '0;
    x[u*RB +: RB] = r;
    return x;
  endfunction

  function automatic logic [127:0] val_at(input int u, input logic [31:0] v);
    logic [127:0] x;
    x = '0;
    x[u*VS +: VS] = v;
    return x;
  endfunction

  function automatic logic [3:0] m_ready(input logic r);
    logic [3:0] res;
    for (int i = 0; i < NU; i++) res[i] = r && (mq[i].size() < DEPTH);
    return res;
  endfunction

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic rf,
                              input logic [27:0] rid, input logic [127:0] val,
                              input logic ev, input logic [1:0] eu,
                              input logic [38:0] ec, input logic [3:0] er);
    vec_t t;
    t.r = r; t.v = v; t.rf = rf; t.rid = rid; t.val = val;
    t.e_valid = ev; t.e_unit = eu; t.e_cdb = ec; t.e_ready = er;
    return t;
  endfunction

  // Model of one falling edge: grant from pre-push contents, then accept pushes.
  task automatic model_edge();
    logic [3:0] acc;
    bit         got;
    int         u;
    cdb_t       e;
    if (!rst) begin
      for (int i = 0; i < NU; i++) mq[i].delete();
      m_rr    = 0;
      m_valid = 1'b0;
      m_unit  = 2'd0;
      m_cdb   = '0;
    end else begin
      for (int i = 0; i < NU; i++) acc[i] = unit_valid[i] && (mq[i].size() < DEPTH);
      got = 1'b0;
      if (!robfull) begin
        for (int k = 0; k < NU; k++) begin
          u = (m_rr + k) % NU;
          if (!got && mq[u].size() > 0) begin
            got    = 1'b1;
            m_cdb  = mq[u].pop_front();
            m_unit = 2'(u);
            m_rr   = (u + 1) % NU;
          end
        end
      end
      m_valid = got;
      for (int i = 0; i < NU; i++) begin
        if (acc[i]) begin
          e.robid = unit_robid[i*RB +: RB];
          e.value = unit_value[i*VS +: VS];
          mq[i].push_back(e);
        end
      end
    end
  endtask

  // driver: apply inputs after a rising edge, let the DUT act on the falling
  // edge, then compare on the next rising edge
  task automatic drive_cycle(input logic r, input logic [3:0] v, input logic rf,
                             input logic [27:0] rid, input logic [127:0] val);
    rst        = r;
    unit_valid = v;
    robfull    = rf;
    unit_robid = rid;
    unit_value = val;
    @(negedge clk);
    model_edge();
    @(posedge clk);
    chk("model_cdb_valid", cdb_valid, m_valid);
    chk("model_cdb_unit", cdb_unit, m_unit);
    chk("model_CDB", CDB, m_cdb);
    chk("model_unit_ready", unit_ready, m_ready(rst));
  endtask

  task automatic idle(input int n, input logic rf);
    for (int i = 0; i < n; i++) drive_cycle(1'b1, 4'b0000, rf, '0, '0);
  endtask

  initial begin
    logic [27:0]  rid_all;
    logic [127:0] val_all;
    bit           seen;
    int           nb;

    rst = 1'b0; unit_valid = '0; robfull = 1'b0; unit_robid = '0; unit_value = '0;

    rid_all = '0;
    val_all = '0;
    for (int u = 0; u < NU; u++) begin
      rid_all |= rid_at(u, 7'(u + 1));
      val_all |= val_at(u, 32'hC0DE_0000 + 32'(u));
    end

    // reset, single result, contention, backpressure
    tbl.push_back(mk(0, 4'b0000, 0, '0, '0, 0, 2'd0, 39'h0, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 0, '0, '0, 0, 2'd0, 39'h0, 4'b0000));
    tbl.push_back(mk(1, 4'b0000, 0, '0, '0, 0, 2'd0, 39'h0, 4'b1111));
    tbl.push_back(mk(1, 4'b0100, 0, rid_at(2, 7'h05), val_at(2, 32'hDEADBEEF),
                     0, 2'd0, 39'h0, 4'b1111));
    tbl.push_back(mk(1, 4'b0000, 0, '0, '0, 1, 2'd2, {7'h05, 32'hDEADBEEF}, 4'b1111));
    tbl.push_back(mk(1, 4'b0000, 0, '0, '0, 0, 2'd2, {7'h05, 32'hDEADBEEF}, 4'b1111));
    tbl.push_back(mk(0, 4'b0000, 0, '0, '0, 0, 2'd0, 39'h0, 4'b0000));
    tbl.push_back(mk(1, 4'b1111, 0, rid_all, val_all, 0, 2'd0, 39'h0, 4'b1111));
    for (int u = 0; u < NU; u++)
      tbl.push_back(mk(1, 4'b0000, 0, '0, '0, 1, 2'(u),
                       {7'(u + 1), 32'hC0DE_0000 + 32'(u)}, 4'b1111));
    tbl.push_back(mk(1, 4'b0000, 0, '0, '0, 0, 2'd3, {7'd4, 32'hC0DE_0003}, 4'b1111));
    tbl.push_back(mk(1, 4'b0010, 1, rid_at(1, 7'd10), val_at(1, 32'hB00C_000A),
                     0, 2'd3, {7'd4, 32'hC0DE_0003}, 4'b1111));
    tbl.push_back(mk(1, 4'b0010, 1, rid_at(1, 7'd11), val_at(1, 32'hB00C_000B),
                     0, 2'd3, {7'd4, 32'hC0DE_0003}, 4'b1101));
    tbl.push_back(mk(1, 4'b0010, 1, rid_at(1, 7'd12), val_at(1, 32'hB00C_000C),
                     0, 2'd3, {7'd4, 32'hC0DE_0003}, 4'b1101));
    tbl.push_back(mk(1, 4'b0010, 0, rid_at(1, 7'd12), val_at(1, 32'hB00C_000C),
                     1, 2'd1, {7'd10, 32'hB00C_000A}, 4'b1111));
    tbl.push_back(mk(1, 4'b0010, 0, rid_at(1, 7'd12), val_at(1, 32'hB00C_000C),
                     1, 2'd1, {7'd11, 32'hB00C_000B}, 4'b1111));
    tbl.push_back(mk(1, 4'b0000, 0, '0, '0, 1, 2'd1, {7'd12, 32'hB00C_000C}, 4'b1111));
    tbl.push_back(mk(1, 4'b0000, 0, '0, '0, 0, 2'd1, {7'd12, 32'hB00C_000C}, 4'b1111));

    @(posedge clk);
    foreach (tbl[i]) begin
      drive_cycle(tbl[i].r, tbl[i].v, tbl[i].rf, tbl[i].rid, tbl[i].val);
      chk($sformatf("row%0d_cdb_valid", i), cdb_valid, tbl[i].e_valid);
      chk($sformatf("row%0d_cdb_unit", i), cdb_unit, tbl[i].e_unit);
      chk($sformatf("row%0d_CDB", i), CDB, tbl[i].e_cdb);
      chk($sformatf("row%0d_unit_ready", i), unit_ready, tbl[i].e_ready);
    end

    // rotation: unit 0 kept busy must not starve unit 3
    for (int i = 0; i < 3; i++)
      drive_cycle(1, 4'b0001, 0, rid_at(0, 7'(8'h20 + i)), val_at(0, 32'h0A00_0000 + 32'(i)));
    drive_cycle(1, 4'b1001, 0, rid_at(0, 7'h23) | rid_at(3, 7'h33),
                val_at(0, 32'h0A00_0003) | val_at(3, 32'h3333_3333));
    seen = 0;
    nb   = 0;
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1, 4'b0001, 0, rid_at(0, 7'(8'h24 + k)), val_at(0, 32'h0A00_0004 + 32'(k)));
      if (cdb_valid) begin
        nb++;
        if (cdb_unit == 2'd3 && nb <= 2) seen = 1;
      end
    end
    chk("rotation_unit3_granted", 64'(seen), 64'd1);
    idle(4, 0);

    // robfull stall with three entries buffered
    drive_cycle(1, 4'b0111, 1, rid_at(0, 7'h40) | rid_at(1, 7'h41) | rid_at(2, 7'h42),
                val_at(0, 32'h4000_0000) | val_at(1, 32'h4100_0000) | val_at(2, 32'h4200_0000));
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1, 4'b0000, 1, '0, '0);
      chk("stall_cdb_valid", cdb_valid, 64'd0);
    end
    idle(4, 0);

    // reset mid-operation drops buffered entries and rewinds the pointer
    drive_cycle(1, 4'b1111, 1, rid_all, val_all);
    drive_cycle(0, 4'b0000, 1, '0, '0);
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1, 4'b0000, 0, '0, '0);
      chk("post_reset_quiet", cdb_valid, 64'd0);
    end
    drive_cycle(1, 4'b1010, 0, rid_at(1, 7'h51) | rid_at(3, 7'h53),
                val_at(1, 32'h5100_0000) | val_at(3, 32'h5300_0000));
    drive_cycle(1, 4'b0000, 0, '0, '0);
    chk("post_reset_first_valid", cdb_valid, 64'd1);
    chk("post_reset_first_unit", cdb_unit, 64'd1);
    idle(2, 0);

    // random traffic against the model
    for (int n = 0; n < 500; n++) begin
      drive_cycle(($urandom_range(0, 60) != 0), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0), 28'($urandom),
                  {$urandom, $urandom, $urandom, $urandom});
    end
    idle(10, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
